// File: rtl/fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// fc_argmax_classifier
//
// Purpose:
//    Final classification stage after the fully-connected layer. Once the FC
//    layer has written NUM_CLASS scores to the shared feature memory and raised
//    layer_end (wired to enable), this block reads the scores back through a
//    synchronous-read memory port. It reports the index and value of the
//    largest signed score.
//
// Ports:
//    clk          in   1      rising-edge clock
//    reset_n      in   1      asynchronous active-low reset
//    enable       in   1      level start/hold (normally FC layer_end)
//    input_value  in   16     signed score; valid one cycle after addr
//    addr         out  16     memory read address
//    class_idx    out  IDX_W  index of the winning score
//    max_value    out  16     signed winning score
//    done         out  1      result valid; held while enable stays high
//
// Configuration macro:
//    ARGMAX_TIE_LAST_EN
//       undefined : strict '>' compare, so the lowest index wins on ties.
//       defined   : '>=' compare, so the highest index wins on ties.
//
// Flow:
//    IDLE -> PRIME -> READ x NUM_CLASS -> DONE -> IDLE (when enable drops).
//    Dropping enable in PRIME or READ aborts the scan and returns to IDLE.
// -----------------------------------------------------------------------------
module fc_argmax_classifier #(
   parameter int unsigned NUM_CLASS = 5,
   parameter logic [15:0] BASE_ADDR = 16'd0,
   parameter int unsigned IDX_W     = 8
) (
   input  logic                    clk,
   input  logic                    reset_n,
   input  logic                    enable,
   input  logic signed [15:0]      input_value,
   output logic        [15:0]      addr,
   output logic        [IDX_W-1:0] class_idx,
   output logic signed [15:0]      max_value,
   output logic                    done
);

   localparam int unsigned CNT_W = $clog2(NUM_CLASS + 1);

   localparam logic [CNT_W-1:0] CNT_ZERO   = {CNT_W{1'b0}};
   localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(NUM_CLASS - 1);
   localparam logic [15:0]      PRIME_ADDR = BASE_ADDR + 16'd1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_PRIME = 2'd1,
      S_READ  = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t                    state_q, state_d;
   logic        [CNT_W-1:0]   cnt_q, cnt_d;
   logic        [15:0]        addr_q, addr_d;
   logic        [IDX_W-1:0]   idx_q, idx_d;
   logic signed [15:0]        max_q, max_d;
   logic                      done_q, done_d;

   logic [CNT_W+IDX_W-1:0]    cnt_wide_s;
   logic [IDX_W-1:0]          cnt_idx_s;
   logic                      better_s;

   // The class index is the score counter zero-extended or truncated to IDX_W.
   assign cnt_wide_s = {{IDX_W{1'b0}}, cnt_q};
   assign cnt_idx_s  = cnt_wide_s[IDX_W-1:0];

   // Signed compare of the incoming score against the running maximum.
`ifdef ARGMAX_TIE_LAST_EN
   assign better_s = (input_value >= max_q);
`else
   assign better_s = (input_value > max_q);
`endif

   // Next-state and next-output computation for the scan sequencer.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      addr_d  = addr_q;
      idx_d   = idx_q;
      max_d   = max_q;
      done_d  = done_q;

      case (state_q)
         S_IDLE: begin
            done_d = 1'b0;
            if (enable) begin
               // Present score 0's address; memory latches it next edge.
               addr_d  = BASE_ADDR;
               state_d = S_PRIME;
            end else begin
               addr_d  = 16'd0;
               state_d = S_IDLE;
            end
         end

         S_PRIME: begin
            if (enable) begin
               addr_d  = PRIME_ADDR;
               cnt_d   = CNT_ZERO;
               state_d = S_READ;
            end else begin
               addr_d  = 16'd0;
               cnt_d   = CNT_ZERO;
               done_d  = 1'b0;
               state_d = S_IDLE;
            end
         end

         S_READ: begin
            if (!enable) begin
               // Abort: partial max/idx may remain but done never rises.
               addr_d  = 16'd0;
               cnt_d   = CNT_ZERO;
               done_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               // Score 0 seeds the running maximum unconditionally.
               if (cnt_q == CNT_ZERO) begin
                  max_d = input_value;
                  idx_d = {IDX_W{1'b0}};
               end else if (better_s) begin
                  max_d = input_value;
                  idx_d = cnt_idx_s;
               end else begin
                  max_d = max_q;
                  idx_d = idx_q;
               end

               cnt_d = cnt_q + CNT_ONE;

               // On the last capture addr already sits at BASE_ADDR+NUM_CLASS
               // and freezes there for the DONE state.
               if (cnt_q == CNT_LAST) begin
                  addr_d  = addr_q;
                  done_d  = 1'b1;
                  state_d = S_DONE;
               end else begin
                  addr_d  = addr_q + 16'd1;
                  done_d  = 1'b0;
                  state_d = S_READ;
               end
            end
         end

         S_DONE: begin
            if (!enable) begin
               // Result registers keep the last answer until the next scan.
               addr_d  = 16'd0;
               cnt_d   = CNT_ZERO;
               done_d  = 1'b0;
               state_d = S_IDLE;
            end else begin
               done_d  = 1'b1;
               state_d = S_DONE;
            end
         end

         default: begin
            addr_d  = 16'd0;
            cnt_d   = CNT_ZERO;
            done_d  = 1'b0;
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset may arrive mid-scan and clears all.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         cnt_q   <= CNT_ZERO;
         addr_q  <= 16'd0;
         idx_q   <= {IDX_W{1'b0}};
         max_q   <= 16'sd0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         addr_q  <= addr_d;
         idx_q   <= idx_d;
         max_q   <= max_d;
         done_q  <= done_d;
      end
   end

   assign addr      = addr_q;
   assign class_idx = idx_q;
   assign max_value = max_q;
   assign done      = done_q;

endmodule

// File: tb/tb_fc_argmax_classifier.sv
// -----------------------------------------------------------------------------
// tb_fc_argmax_classifier
//
// Directed bench for fc_argmax_classifier (NUM_CLASS=5, BASE_ADDR=0, IDX_W=8).
// A synchronous-read memory model feeds input_value. A scan model counts the
// edges since enable rose and derives addr/done/result from that count and
// the memory contents; a compare process checks it every falling edge.
// Directed tasks add literal expectations for each scenario.
// -----------------------------------------------------------------------------
module tb_fc_argmax_classifier;

   localparam int          N    = 5;
   localparam logic [15:0] BASE = 16'd0;

`ifdef ARGMAX_TIE_LAST_EN
   localparam int T2_IDX = 4;
   localparam int T3_IDX = 3;
`else
   localparam int T2_IDX = 0;
   localparam int T3_IDX = 1;
`endif

   logic               clk     = 1'b0;
   logic               reset_n = 1'b0;
   logic               enable  = 1'b0;
   logic signed [15:0] input_value;
   logic        [15:0] addr;
   logic        [7:0]  class_idx;
   logic signed [15:0] max_value;
   logic               done;

   logic signed [15:0] mem [0:255];

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   fc_argmax_classifier #(
      .NUM_CLASS (N),
      .BASE_ADDR (BASE),
      .IDX_W     (8)
   ) dut (
      .clk         (clk),
      .reset_n     (reset_n),
      .enable      (enable),
      .input_value (input_value),
      .addr        (addr),
      .class_idx   (class_idx),
      .max_value   (max_value),
      .done        (done)
   );

   // synchronous-read memory: data valid one cycle after the address
   always @(posedge clk) input_value <= mem[addr[7:0]];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // plain argmax over the stored scores, with the build's tie rule
   function automatic void model_argmax(output int idx, output logic signed [15:0] mx);
      idx = 0;
      mx  = mem[BASE];
      for (int i = 1; i < N; i++) begin
`ifdef ARGMAX_TIE_LAST_EN
         if (mem[BASE + 16'(i)] >= mx) begin
`else
         if (mem[BASE + 16'(i)] > mx) begin
`endif
            idx = i;
            mx  = mem[BASE + 16'(i)];
         end
      end
   endfunction

   // scan model: k = rising edges since enable was first sampled high
   int                 k        = 0;
   logic               held_ok  = 1'b1;
   int                 held_idx = 0;
   logic signed [15:0] held_max = 16'sd0;

   always @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         k        = 0;
         held_ok  = 1'b1;
         held_idx = 0;
         held_max = 16'sd0;
      end else if (enable) begin
         if (k < 1000) k = k + 1;
         if (k == 1) held_ok = 1'b0;
         if (k == N + 2) begin
            model_argmax(held_idx, held_max);
            held_ok = 1'b1;
         end
      end else begin
         k = 0;
      end
   end

   int                 cmp_idx;
   logic signed [15:0] cmp_max;
   logic        [15:0] cmp_addr;

   always @(negedge clk) begin
      if (k == 0) cmp_addr = 16'd0;
      else        cmp_addr = BASE + 16'(((k - 1) < N) ? (k - 1) : N);
      chk("m_addr", 32'(addr), 32'(cmp_addr));
      chk("m_done", 32'(done), 32'(k >= N + 2));
      if (k >= N + 2) begin
         model_argmax(cmp_idx, cmp_max);
         chk("m_class_idx", 32'(class_idx), 32'(cmp_idx));
         chk("m_max_value", {16'd0, max_value}, {16'd0, cmp_max});
      end else if (k == 0 && held_ok) begin
         chk("m_held_idx", 32'(class_idx), 32'(held_idx));
         chk("m_held_max", {16'd0, max_value}, {16'd0, held_max});
      end
   end

   task automatic load(input logic [15:0] s0, input logic [15:0] s1, input logic [15:0] s2,
                       input logic [15:0] s3, input logic [15:0] s4);
      mem[0] = s0; mem[1] = s1; mem[2] = s2; mem[3] = s3; mem[4] = s4;
   endtask

   // raise enable, wait (bounded) for done, check latency and result, drop enable
   task automatic run_scan(input string tag, input int exp_idx, input logic [15:0] exp_max);
      int cyc;
      cyc = 0;
      @(negedge clk);
      enable = 1'b1;
      while (cyc < 30) begin
         @(negedge clk);
         cyc++;
         if (done) break;
      end
      chk({tag, "_latency"}, 32'(cyc), 32'd7);
      chk({tag, "_idx"}, 32'(class_idx), 32'(exp_idx));
      chk({tag, "_max"}, {16'd0, max_value}, {16'd0, exp_max});
      enable = 1'b0;
      @(negedge clk);
      chk({tag, "_idle_addr"}, 32'(addr), 32'd0);
      chk({tag, "_idle_done"}, 32'(done), 32'd0);
   endtask

   logic [15:0] t1_addr [0:6];
   int          seen_done;
   int          cyc6;

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 16'sd0;
      t1_addr[0] = 16'd0; t1_addr[1] = 16'd1; t1_addr[2] = 16'd2; t1_addr[3] = 16'd3;
      t1_addr[4] = 16'd4; t1_addr[5] = 16'd5; t1_addr[6] = 16'd5;

      // reset state
      repeat (2) @(negedge clk);
      chk("rst_addr", 32'(addr), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_idx", 32'(class_idx), 32'd0);
      chk("rst_max", {16'd0, max_value}, 32'd0);
      reset_n = 1'b1;
      @(negedge clk);

      // test 1: address sequence and result
      load(16'h0100, 16'h0480, 16'h0200, 16'h0000, 16'h0300);
      enable = 1'b1;
      for (int j = 1; j <= 7; j++) begin
         @(negedge clk);
         chk("t1_addr", 32'(addr), 32'(t1_addr[j-1]));
         chk("t1_done", 32'(done), 32'(j == 7));
      end
      chk("t1_idx", 32'(class_idx), 32'd1);
      chk("t1_max", {16'd0, max_value}, 32'h0480);
      enable = 1'b0;
      @(negedge clk);

      // test 2: all zero scores
      load(16'h0000, 16'h0000, 16'h0000, 16'h0000, 16'h0000);
      run_scan("t2", T2_IDX, 16'h0000);

      // test 3: tie on the maximum
      load(16'h0200, 16'h0700, 16'h0100, 16'h0700, 16'h0050);
      run_scan("t3", T3_IDX, 16'h0700);

      // test 4: negative scores, signed compare
      load(16'hFF00, 16'hFE00, 16'hFFF0, 16'h8000, 16'hFF80);
      run_scan("t4", 2, 16'hFFF0);

      // test 5: abort at third READ edge, then a clean rescan
      load(16'h0200, 16'h0700, 16'h0100, 16'h0700, 16'h0050);
      seen_done = 0;
      enable = 1'b1;
      repeat (4) begin
         @(negedge clk);
         if (done) seen_done++;
      end
      enable = 1'b0;
      @(negedge clk);
      if (done) seen_done++;
      chk("t5_abort_addr", 32'(addr), 32'd0);
      chk("t5_abort_done", 32'(seen_done), 32'd0);
      load(16'h0100, 16'h0480, 16'h0200, 16'h0000, 16'h0300);
      run_scan("t5", 1, 16'h0480);

      // test 6: async reset mid-READ, then full scan and long DONE hold
      load(16'h0300, 16'h0100, 16'h0480, 16'h0000, 16'h0200);
      enable = 1'b1;
      repeat (4) @(negedge clk);
      #2 reset_n = 1'b0;
      #1;
      chk("t6_rst_addr", 32'(addr), 32'd0);
      chk("t6_rst_done", 32'(done), 32'd0);
      chk("t6_rst_idx", 32'(class_idx), 32'd0);
      chk("t6_rst_max", {16'd0, max_value}, 32'd0);
      @(negedge clk);
      reset_n = 1'b1;
      cyc6 = 0;
      while (cyc6 < 30) begin
         @(negedge clk);
         cyc6++;
         if (done) break;
      end
      chk("t6_latency", 32'(cyc6), 32'd7);
      chk("t6_idx", 32'(class_idx), 32'd2);
      chk("t6_max", {16'd0, max_value}, 32'h0480);
      repeat (20) begin
         @(negedge clk);
         chk("t6_hold_done", 32'(done), 32'd1);
         chk("t6_hold_idx", 32'(class_idx), 32'd2);
         chk("t6_hold_max", {16'd0, max_value}, 32'h0480);
         chk("t6_hold_addr", 32'(addr), 32'd5);
      end
      enable = 1'b0;
      @(negedge clk);
      chk("t6_exit_done", 32'(done), 32'd0);
      chk("t6_exit_addr", 32'(addr), 32'd0);
      chk("t6_keep_idx", 32'(class_idx), 32'd2);
      chk("t6_keep_max", {16'd0, max_value}, 32'h0480);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
